// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-read-port register file.
// Default widths here are also consumed by the decode stage.
package regfile_mp_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 32;
   localparam int DEF_NUM_RD = 2;
   localparam int MAX_RD     = 4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   // Low bit of port k inside a flattened per-port bus of width w.
   function automatic int unsigned port_lo(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the writeback/decode stages (master) and regfile_mp (slave).
interface regfile_mp_if
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NUM_RD = DEF_NUM_RD
) ();

   localparam int ADDR_W = $clog2(DEPTH);

   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_pend;
   logic                     alloc_en;
   logic [ADDR_W-1:0]        alloc_addr;
   logic                     clr_req;
   logic                     busy;
   logic                     clr_done;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, alloc_en, alloc_addr, clr_req,
      input  rd_data, rd_pend, busy, clr_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, alloc_en, alloc_addr, clr_req,
      output rd_data, rd_pend, busy, clr_done
   );

endinterface

// File: rtl/regfile_mp_rdport.sv
// One read port: pend lookup, optional write-to-read bypass, zero-register mask.
// Bypass compiled in with `define REGFILE_MP_BYPASS_EN.
module regfile_mp_rdport
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ZERO_REG = 1,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_mem_data,
   input  logic [DEPTH-1:0]  i_pend,
`ifdef REGFILE_MP_BYPASS_EN
   input  logic              i_wr_fwd,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_alloc_fwd,
   input  logic [ADDR_W-1:0] i_alloc_addr,
`endif
   output logic [DATA_W-1:0] o_data,
   output logic              o_pend
);

   logic w_zero;

   assign w_zero = (ZERO_REG != 0) && (i_addr == '0);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      o_data = i_mem_data;
      o_pend = i_pend[i_addr];
`ifdef REGFILE_MP_BYPASS_EN
      // A same-cycle alloc to the written register means a new producer, so it stays pending.
      if (i_wr_fwd && (i_addr == i_wr_addr)) begin
         o_data = i_wr_data;
         o_pend = i_alloc_fwd && (i_alloc_addr == i_wr_addr);
      end
`endif
      if (w_zero) begin
         o_data = '0;
         o_pend = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending scoreboard and sequential clear sweep.
// Optional same-cycle write bypass: `define REGFILE_MP_BYPASS_EN.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   regfile_mp_if.slave  bus
);

   localparam int ADDR_W = $clog2(DEPTH);

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_busy;
   logic              r_clr_done;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_pend;

   logic              w_wr_fire;
   logic              w_alloc_fire;
   logic [DATA_W-1:0] w_rd_data [NUM_RD];
   logic [NUM_RD-1:0] w_rd_pend;

   assign w_wr_fire    = bus.wr_en && !r_busy &&
                         ((ZERO_REG == 0) || (bus.wr_addr != '0));
   assign w_alloc_fire = bus.alloc_en && !r_busy &&
                         ((ZERO_REG == 0) || (bus.alloc_addr != '0));

   assign bus.busy     = r_busy;
   assign bus.clr_done = r_clr_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_clr_done <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_clr_done <= 1'b0;
               if (bus.clr_req) begin
                  r_state <= ST_SWEEP;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_SWEEP: begin
               r_cnt      <= r_cnt + 1'b1;
               // Registered pulse lands on the cycle where cnt == DEPTH-1.
               r_clr_done <= (r_cnt == ADDR_W'(DEPTH - 2));
               if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: the storage array is reset on purpose; every register must read 0 after reset,
   // which rules out a RAM macro and keeps this a flop array.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == ST_SWEEP) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_fire) begin
         r_mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend <= '0;
      end else if (r_state == ST_SWEEP) begin
         r_pend[r_cnt] <= 1'b0;
      end else begin
         // NOTE: with non-blocking assignments the last one in program order wins,
         // so a same-address alloc overrides the retire clear.
         if (w_wr_fire) begin
            r_pend[bus.wr_addr] <= 1'b0;
         end
         if (w_alloc_fire) begin
            r_pend[bus.alloc_addr] <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;

      assign w_addr = bus.rd_addr[port_lo(k, ADDR_W) +: ADDR_W];

      regfile_mp_rdport #(
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .ZERO_REG (ZERO_REG),
         .ADDR_W   (ADDR_W)
      ) u_rdport (
         .i_addr       (w_addr),
         .i_mem_data   (r_mem[w_addr]),
         .i_pend       (r_pend),
`ifdef REGFILE_MP_BYPASS_EN
         .i_wr_fwd     (w_wr_fire),
         .i_wr_addr    (bus.wr_addr),
         .i_wr_data    (bus.wr_data),
         .i_alloc_fwd  (w_alloc_fire),
         .i_alloc_addr (bus.alloc_addr),
`endif
         .o_data       (w_rd_data[k]),
         .o_pend       (w_rd_pend[k])
      );
   end

   always_comb begin
      bus.rd_data = '0;
      bus.rd_pend = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         bus.rd_data[port_lo(k, DATA_W) +: DATA_W] = w_rd_data[k];
         bus.rd_pend[k]                            = w_rd_pend[k];
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (32x32, two read ports, zero register).
// Bypass expectations follow REGFILE_MP_BYPASS_EN when it is defined for the build.
module tb_regfile_mp;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int NUM_RD = 2;
   localparam int ADDR_W = 5;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   regfile_mp_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();

   regfile_mp #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
      bus.rd_addr = {a1, a0};
      #1;
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      cycle();
      bus.wr_en   = 1'b0;
   endtask

   task automatic do_alloc(input logic [ADDR_W-1:0] a);
      bus.alloc_en   = 1'b1;
      bus.alloc_addr = a;
      cycle();
      bus.alloc_en   = 1'b0;
   endtask

   task automatic test_reset();
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.alloc_en   = 1'b0;
      bus.alloc_addr = '0;
      bus.clr_req    = 1'b0;
      bus.rd_addr    = '0;
      reset_n        = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      cycle();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.clr_done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_status busy=%b clr_done=%b want 0/0", bus.busy, bus.clr_done);
      end
      for (int i = 0; i < DEPTH; i++) begin
         set_rd(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
         n_checks++;
         if (bus.rd_data !== '0 || bus.rd_pend !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_read addr=%0d got data=%h pend=%b want 0", i, bus.rd_data, bus.rd_pend);
         end
      end
   endtask

   task automatic test_write_read();
      do_write(5'd5, 32'hDEAD_BEEF);
      do_write(5'd0, 32'h1234_5678);
      set_rd(5'd5, 5'd0);
      n_checks++;
      if (bus.rd_data[31:0] !== 32'hDEAD_BEEF || bus.rd_pend[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL write_r5 got %h pend=%b want deadbeef pend=0", bus.rd_data[31:0], bus.rd_pend[0]);
      end
      n_checks++;
      if (bus.rd_data[63:32] !== 32'h0 || bus.rd_pend[1] !== 1'b0) begin
         n_errors++;
         $display("FAIL zero_reg got %h pend=%b want 0", bus.rd_data[63:32], bus.rd_pend[1]);
      end
   endtask

   task automatic test_scoreboard();
      do_alloc(5'd7);
      set_rd(5'd7, 5'd0);
      n_checks++;
      if (bus.rd_pend !== 2'b01) begin
         n_errors++;
         $display("FAIL alloc_r7 got pend=%b want 01", bus.rd_pend);
      end
      cycle();
      n_checks++;
      if (bus.rd_pend !== 2'b01) begin
         n_errors++;
         $display("FAIL alloc_r7_hold got pend=%b want 01", bus.rd_pend);
      end
      do_write(5'd7, 32'hA5A5_A5A5);
      set_rd(5'd7, 5'd7);
      n_checks++;
      if (bus.rd_data !== {2{32'hA5A5_A5A5}} || bus.rd_pend !== 2'b00) begin
         n_errors++;
         $display("FAIL retire_r7 got data=%h pend=%b want a5a5a5a5 x2 pend=00", bus.rd_data, bus.rd_pend);
      end
      bus.wr_en      = 1'b1;
      bus.wr_addr    = 5'd9;
      bus.wr_data    = 32'h9999_0009;
      bus.alloc_en   = 1'b1;
      bus.alloc_addr = 5'd9;
      cycle();
      bus.wr_en      = 1'b0;
      bus.alloc_en   = 1'b0;
      set_rd(5'd9, 5'd0);
      n_checks++;
      if (bus.rd_data[31:0] !== 32'h9999_0009 || bus.rd_pend !== 2'b01) begin
         n_errors++;
         $display("FAIL wr_alloc_r9 got data=%h pend=%b want 99990009 pend=01", bus.rd_data[31:0], bus.rd_pend);
      end
      do_alloc(5'd0);
      set_rd(5'd0, 5'd9);
      n_checks++;
      if (bus.rd_pend !== 2'b10 || bus.rd_data[31:0] !== 32'h0) begin
         n_errors++;
         $display("FAIL alloc_r0 got data=%h pend=%b want 0 pend=10", bus.rd_data[31:0], bus.rd_pend);
      end
   endtask

   task automatic test_clear_sweep();
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_at  = -1;
      for (int i = 1; i < DEPTH; i++) begin
         do_write(ADDR_W'(i), DATA_W'(i));
      end
      do_alloc(5'd12);
      set_rd(5'd30, 5'd12);
      n_checks++;
      if (bus.rd_data[31:0] !== 32'd30 || bus.rd_data[63:32] !== 32'd12 || bus.rd_pend !== 2'b10) begin
         n_errors++;
         $display("FAIL fill got data=%h pend=%b want 0000000c0000001e pend=10", bus.rd_data, bus.rd_pend);
      end
      bus.clr_req = 1'b1;
      cycle();
      bus.clr_req = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.clr_done === 1'b1) begin
            done_cnt++;
            done_at = i;
         end
         if (i == 5) begin
            set_rd(5'd1, 5'd20);
            n_checks++;
            if (bus.rd_data[31:0] !== 32'd0 || bus.rd_data[63:32] !== 32'd20) begin
               n_errors++;
               $display("FAIL partial_clear got r1=%h r20=%h want 0/14", bus.rd_data[31:0], bus.rd_data[63:32]);
            end
            bus.wr_en      = 1'b1;
            bus.wr_addr    = 5'd3;
            bus.wr_data    = 32'hFFFF_FFFF;
            bus.alloc_en   = 1'b1;
            bus.alloc_addr = 5'd2;
         end
         if (i == 6) begin
            bus.wr_en    = 1'b0;
            bus.alloc_en = 1'b0;
            bus.clr_req  = 1'b1;
         end
         if (i == 7) bus.clr_req = 1'b0;
         cycle();
      end
      n_checks++;
      if (busy_cnt != 32) begin
         n_errors++;
         $display("FAIL busy_len got %0d cycles want 32", busy_cnt);
      end
      n_checks++;
      if (done_cnt != 1 || done_at != 31) begin
         n_errors++;
         $display("FAIL clr_done got %0d pulses last at %0d want 1 at 31", done_cnt, done_at);
      end
      for (int i = 0; i < DEPTH; i++) begin
         set_rd(ADDR_W'(i), ADDR_W'(i));
         n_checks++;
         if (bus.rd_data !== '0 || bus.rd_pend !== 2'b00) begin
            n_errors++;
            $display("FAIL after_sweep addr=%0d got data=%h pend=%b want 0", i, bus.rd_data, bus.rd_pend);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int seen_done = 0;
      do_write(5'd20, 32'h0000_2020);
      do_alloc(5'd25);
      bus.clr_req = 1'b1;
      cycle();
      bus.clr_req = 1'b0;
      repeat (10) begin
         if (bus.clr_done === 1'b1) seen_done++;
         cycle();
      end
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL sweep_running got busy=%b want 1", bus.busy);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.clr_done !== 1'b0) begin
         n_errors++;
         $display("FAIL async_reset got busy=%b clr_done=%b want 0/0", bus.busy, bus.clr_done);
      end
      repeat (3) begin
         if (bus.clr_done === 1'b1) seen_done++;
         cycle();
      end
      reset_n = 1'b1;
      repeat (40) begin
         if (bus.clr_done === 1'b1 || bus.busy === 1'b1) seen_done++;
         cycle();
      end
      n_checks++;
      if (seen_done != 0) begin
         n_errors++;
         $display("FAIL no_done_after_reset got %0d busy/done samples want 0", seen_done);
      end
      for (int i = 0; i < DEPTH; i++) begin
         set_rd(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
         n_checks++;
         if (bus.rd_data !== '0 || bus.rd_pend !== 2'b00) begin
            n_errors++;
            $display("FAIL mid_reset_read addr=%0d got data=%h pend=%b want 0", i, bus.rd_data, bus.rd_pend);
         end
      end
   endtask

   task automatic test_bypass();
      logic [DATA_W-1:0] exp_d;
      logic              exp_p;
      do_write(5'd4, 32'h1111_1111);
      do_alloc(5'd4);
      set_rd(5'd0, 5'd4);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd4;
      bus.wr_data = 32'h0BAD_F00D;
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      exp_d = 32'h0BAD_F00D;
      exp_p = 1'b0;
`else
      exp_d = 32'h1111_1111;
      exp_p = 1'b1;
`endif
      n_checks++;
      if (bus.rd_data[63:32] !== exp_d || bus.rd_pend[1] !== exp_p) begin
         n_errors++;
         $display("FAIL bypass_same_cycle got %h pend=%b want %h pend=%b", bus.rd_data[63:32], bus.rd_pend[1], exp_d, exp_p);
      end
      cycle();
      bus.wr_en = 1'b0;
      #1;
      n_checks++;
      if (bus.rd_data[63:32] !== 32'h0BAD_F00D || bus.rd_pend[1] !== 1'b0) begin
         n_errors++;
         $display("FAIL bypass_next_cycle got %h pend=%b want 0badf00d pend=0", bus.rd_data[63:32], bus.rd_pend[1]);
      end
      bus.wr_en      = 1'b1;
      bus.wr_data    = 32'h5555_AAAA;
      bus.alloc_en   = 1'b1;
      bus.alloc_addr = 5'd4;
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      exp_d = 32'h5555_AAAA;
      exp_p = 1'b1;
`else
      exp_d = 32'h0BAD_F00D;
      exp_p = 1'b0;
`endif
      n_checks++;
      if (bus.rd_data[63:32] !== exp_d || bus.rd_pend[1] !== exp_p) begin
         n_errors++;
         $display("FAIL bypass_alloc got %h pend=%b want %h pend=%b", bus.rd_data[63:32], bus.rd_pend[1], exp_d, exp_p);
      end
      cycle();
      bus.wr_en    = 1'b0;
      bus.alloc_en = 1'b0;
      #1;
      n_checks++;
      if (bus.rd_data[63:32] !== 32'h5555_AAAA || bus.rd_pend[1] !== 1'b1) begin
         n_errors++;
         $display("FAIL wr_alloc_r4 got %h pend=%b want 5555aaaa pend=1", bus.rd_data[63:32], bus.rd_pend[1]);
      end
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd0;
      bus.wr_data = 32'hFFFF_FFFF;
      #1;
      n_checks++;
      if (bus.rd_data[31:0] !== 32'h0 || bus.rd_pend[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL bypass_r0 got %h pend=%b want 0 pend=0", bus.rd_data[31:0], bus.rd_pend[0]);
      end
      cycle();
      bus.wr_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_scoreboard();
      test_clear_sweep();
      test_reset_mid_sweep();
      test_bypass();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
